// File: rtl/ppu_clock_sched.sv
// ppu_clock_sched: run-control scheduler for the PPU master clock.
// Accepts STOP / RUN_FREE / RUN_N / RUN_UNTIL commands, stalls the clock
// generator when a bounded run reaches its target, waits for the generator
// to park, then reports completion with a one-cycle done pulse.
module ppu_clock_sched #(
  parameter int COUNTER_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_op,
  input  logic [COUNTER_BITS-1:0] cmd_arg,
  output logic                    cmd_ready,
  input  logic                    ext_hold_i,
  input  logic [COUNTER_BITS-1:0] xin_counter_i,
  input  logic                    xin_parked_i,
  output logic                    xin_stall_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    done_aborted_o,
  output logic [COUNTER_BITS-1:0] elapsed_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] OP_STOP      = 2'd0;
  localparam logic [1:0] OP_RUN_FREE  = 2'd1;
  localparam logic [1:0] OP_RUN_N     = 2'd2;
  localparam logic [1:0] OP_RUN_UNTIL = 2'd3;

  state_t                  state_r, next_state_s;
  logic                    bounded_r, next_bounded_s;
  logic [COUNTER_BITS-1:0] target_r, next_target_s;
  logic [COUNTER_BITS-1:0] base_r, next_base_s;
  logic                    abort_r, next_abort_s;
  logic                    done_r, next_done_s;
  logic                    done_aborted_r, next_done_aborted_s;

  logic                    accept_s;
  logic                    match_s;
  logic [COUNTER_BITS-1:0] cmd_target_s;
  logic                    cmd_immediate_s;

  // Handshake, stall and status outputs derived from current state.
  // Equality-only target compare keeps runs across counter wrap correct.
  always_comb begin
    match_s        = (state_r == ST_RUN) && bounded_r && (xin_counter_i == target_r);
    xin_stall_o    = (state_r != ST_RUN) || ext_hold_i || match_s;
    cmd_ready      = (state_r != ST_DRAIN);
    busy_o         = (state_r != ST_IDLE);
    accept_s       = cmd_valid && cmd_ready;
    done_o         = done_r;
    done_aborted_o = done_aborted_r;
    elapsed_o      = xin_counter_i - base_r;
  end

  // Target a run command would load, and whether it is already satisfied.
  always_comb begin
    cmd_target_s    = target_r;
    cmd_immediate_s = 1'b0;
    case (cmd_op)
      OP_RUN_N: begin
        cmd_target_s    = xin_counter_i + cmd_arg;
        cmd_immediate_s = (cmd_arg == {COUNTER_BITS{1'b0}});
      end
      OP_RUN_UNTIL: begin
        cmd_target_s    = cmd_arg;
        cmd_immediate_s = (cmd_arg == xin_counter_i);
      end
      default: begin
        cmd_target_s    = target_r;
        cmd_immediate_s = 1'b0;
      end
    endcase
  end

  // Next-state and register-update logic; commands outrank a target match.
  always_comb begin
    next_state_s        = state_r;
    next_bounded_s      = bounded_r;
    next_target_s       = target_r;
    next_base_s         = base_r;
    next_abort_s        = abort_r;
    next_done_s         = 1'b0;
    next_done_aborted_s = done_aborted_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (accept_s) begin
          if (cmd_op == OP_STOP) begin
            // STOP while idle is a no-op; in RUN it aborts the run.
            if (state_r == ST_RUN) begin
              next_state_s = ST_DRAIN;
              next_abort_s = 1'b1;
            end else begin
              next_state_s = ST_IDLE;
            end
          end else begin
            next_base_s    = xin_counter_i;
            next_target_s  = cmd_target_s;
            next_bounded_s = (cmd_op != OP_RUN_FREE);
            next_abort_s   = 1'b0;
            if (cmd_immediate_s) begin
              next_state_s = ST_DRAIN;
            end else begin
              next_state_s = ST_RUN;
            end
          end
        end else if (match_s) begin
          next_state_s = ST_DRAIN;
          next_abort_s = 1'b0;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (xin_parked_i) begin
          next_state_s        = ST_IDLE;
          next_done_s         = 1'b1;
          next_done_aborted_s = abort_r;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and run-context registers; reset abandons any run silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      bounded_r      <= 1'b0;
      target_r       <= {COUNTER_BITS{1'b0}};
      base_r         <= {COUNTER_BITS{1'b0}};
      abort_r        <= 1'b0;
      done_r         <= 1'b0;
      done_aborted_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      bounded_r      <= next_bounded_s;
      target_r       <= next_target_s;
      base_r         <= next_base_s;
      abort_r        <= next_abort_s;
      done_r         <= next_done_s;
      done_aborted_r <= next_done_aborted_s;
    end
  end

  // Unused-opcode reference keeps the opcode table complete for readers.
  logic unused_op_s;
  always_comb begin
    unused_op_s = (OP_RUN_UNTIL == 2'd3) && (OP_RUN_N == 2'd2);
  end

endmodule
